// File: rtl/mem_bus_pkg.sv
// Shared types and configuration checks for the mem_bus_slave memory slave.
// Imported by the top level and the read pipeline.
package mem_bus_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    localparam int unsigned MIN_DEPTH  = 2;
    localparam int unsigned MIN_RD_LAT = 1;

    // The shift is limited to addr_w < 31 because wider address buses can hold any int depth.
    function automatic bit cfg_ok(input int data_w, input int addr_w,
                                  input int depth, input int rd_lat);
        bit fits;
        fits = (addr_w >= 31) ? 1'b1 : (depth <= (1 << addr_w));
        return (data_w >= 1) && (depth >= int'(MIN_DEPTH)) &&
               (rd_lat >= int'(MIN_RD_LAT)) && fits;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: carries {valid, out-of-range, data} from the read port to the outputs.
// The data of each stage only moves with a valid beat, so the final stage holds its last value.
module mem_rd_pipe
#(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic              in_oor_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic              out_err_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] oor_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // Index 0 is the incoming beat, index i+1 is the output of stage i.
    logic [RD_LAT:0]   src_vld;
    logic [RD_LAT:0]   src_oor;
    logic [DATA_W-1:0] src_dat [RD_LAT+1];

    assign src_vld = {vld_q, in_valid_i};
    assign src_oor = {oor_q, in_oor_i};

    always_comb begin
        src_dat[0] = in_data_i;
        for (int i = 0; i < RD_LAT; i++) begin
            src_dat[i+1] = dat_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            oor_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= src_vld[RD_LAT-1:0];
            oor_q <= src_oor[RD_LAT-1:0];
            for (int i = 0; i < RD_LAT; i++) begin
                if (src_vld[i]) begin
                    dat_q[i] <= src_dat[i];
                end
            end
        end
    end

    assign out_valid_o = vld_q[RD_LAT-1];
    assign out_err_o   = vld_q[RD_LAT-1] & oor_q[RD_LAT-1];
    assign out_data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/mem_bus_slave.sv
// Memory slave on a split read/write bus: self-clears after reset, returns reads after
// RD_LAT cycles with rvalid, and flags out-of-range accesses on err.
module mem_bus_slave
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 2
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              ready,
    output logic              err
);

    localparam bit              CFG_OK   = cfg_ok(DATA_W, ADDR_W, DEPTH, RD_LAT);
    localparam int              CNT_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    if (!CFG_OK) begin : g_cfg_err
        $error("mem_bus_slave: illegal DATA_W/ADDR_W/DEPTH/RD_LAT combination");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_err_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              w_in_range, r_in_range;
    logic              wr_acc, wr_oor, rd_acc;
    logic [DATA_W-1:0] rd_word;
    logic              rd_err;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_err_q <= wr_oor;
        end
    end

    // Gating with rst_n keeps requests out while reset is held, even before the state register reacts.
    assign ready      = rst_n & (state_q == RUN);
    assign w_in_range = {1'b0, waddr} < DEPTH_A;
    assign r_in_range = {1'b0, raddr} < DEPTH_A;
    assign wr_acc     = ready & enable & write & w_in_range;
    assign wr_oor     = ready & enable & write & ~w_in_range;
    assign rd_acc     = ready & enable & read;

    // NOTE: the array has no reset branch; the CLEAR walk zeroes it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem_q[waddr[CNT_W-1:0]] <= wdata;
        end
    end

    // Sampled before the write edge lands, which gives read-before-write on a same-address collision.
    assign rd_word = r_in_range ? mem_q[raddr[CNT_W-1:0]] : '0;

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (rd_acc),
        .in_oor_i    (~r_in_range),
        .in_data_i   (rd_word),
        .out_valid_o (rvalid),
        .out_err_o   (rd_err),
        .out_data_o  (rdata)
    );

    assign err = wr_err_q | rd_err;

endmodule

// File: tb/tb_mem_bus_slave.sv
// Directed bench for mem_bus_slave (DATA_W=8, ADDR_W=8, DEPTH=16, RD_LAT=2):
// a per-cycle vector table plus hand sequences for reset, clear and mid-read reset.
module tb_mem_bus_slave;

    logic       clk = 1'b0;
    logic       rst_n, enable, write, read;
    logic [7:0] waddr, wdata, raddr;
    logic [7:0] rdata;
    logic       rvalid, ready, err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       we;
        logic [7:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [7:0] ra;
        logic       exp_rv;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    localparam int NVEC = 28;
    vec_t       vecs [NVEC];
    logic [7:0] exp_mem [16];

    mem_bus_slave #(
        .DATA_W (8),
        .ADDR_W (8),
        .DEPTH  (16),
        .RD_LAT (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .write  (write),
        .read   (read),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr  (raddr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .ready  (ready),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        enable = 1'b0; write = 1'b0; read = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;
    endtask

    function automatic vec_t v(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                               input logic re, input logic [7:0] ra,
                               input logic rv, input logic [7:0] rd, input logic er);
        vec_t r;
        r.we = we; r.wa = wa; r.wd = wd; r.re = re; r.ra = ra;
        r.exp_rv = rv; r.exp_rd = rd; r.exp_err = er;
        return r;
    endfunction

    // Counts cycles with ready low after reset release; flags any rvalid/err while clearing.
    task automatic wait_ready(input string tag);
        int n = 0;
        bit stray = 1'b0;
        while (!ready && n < 100) begin
            if (rvalid || err) stray = 1'b1;
            n++;
            tick();
        end
        check({tag, ".ready_low_cycles"}, n, 16);
        check({tag, ".no_rvalid_err_in_clear"}, stray, 0);
    endtask

    // Single read: expect rvalid with the given data after the pipeline latency.
    task automatic read_one(input string tag, input logic [7:0] a, input logic [7:0] exp_d);
        enable = 1'b1; read = 1'b1; raddr = a;
        tick();
        idle();
        check({tag, ".rvalid_early"}, rvalid, 0);
        tick();
        check({tag, ".rvalid"}, rvalid, 1);
        check({tag, ".rdata"}, rdata, exp_d);
        check({tag, ".err"}, err, 0);
    endtask

    initial begin
        // Each row is one request cycle; expectations are the outputs seen in the following cycle.
        vecs[0]  = v(0, 8'd0,  8'h00, 1, 8'd5,  0, 8'h00, 0);
        vecs[1]  = v(1, 8'd3,  8'hA5, 0, 8'd0,  1, 8'h00, 0);
        vecs[2]  = v(0, 8'd0,  8'h00, 1, 8'd3,  0, 8'h00, 0);
        vecs[3]  = v(1, 8'd7,  8'h11, 0, 8'd0,  1, 8'hA5, 0);
        vecs[4]  = v(1, 8'd7,  8'h3C, 1, 8'd7,  0, 8'hA5, 0);
        vecs[5]  = v(0, 8'd0,  8'h00, 1, 8'd7,  1, 8'h11, 0);
        vecs[6]  = v(1, 8'd0,  8'h10, 0, 8'd0,  1, 8'h3C, 0);
        vecs[7]  = v(1, 8'd1,  8'h11, 0, 8'd0,  0, 8'h3C, 0);
        vecs[8]  = v(1, 8'd2,  8'h12, 0, 8'd0,  0, 8'h3C, 0);
        vecs[9]  = v(1, 8'd3,  8'h13, 0, 8'd0,  0, 8'h3C, 0);
        vecs[10] = v(0, 8'd0,  8'h00, 1, 8'd0,  0, 8'h3C, 0);
        vecs[11] = v(0, 8'd0,  8'h00, 1, 8'd1,  1, 8'h10, 0);
        vecs[12] = v(0, 8'd0,  8'h00, 1, 8'd2,  1, 8'h11, 0);
        vecs[13] = v(0, 8'd0,  8'h00, 1, 8'd3,  1, 8'h12, 0);
        vecs[14] = v(0, 8'd0,  8'h00, 0, 8'd0,  1, 8'h13, 0);
        vecs[15] = v(0, 8'd0,  8'h00, 1, 8'd20, 0, 8'h13, 0);
        vecs[16] = v(0, 8'd0,  8'h00, 0, 8'd0,  1, 8'h00, 1);
        vecs[17] = v(1, 8'd20, 8'hFF, 0, 8'd0,  0, 8'h00, 1);
        vecs[18] = v(0, 8'd0,  8'h00, 0, 8'd0,  0, 8'h00, 0);
        vecs[19] = v(1, 8'd21, 8'hFF, 1, 8'd20, 0, 8'h00, 1);
        vecs[20] = v(0, 8'd0,  8'h00, 0, 8'd0,  1, 8'h00, 1);
        vecs[21] = v(0, 8'd0,  8'h00, 1, 8'd30, 0, 8'h00, 0);
        vecs[22] = v(1, 8'd25, 8'h09, 0, 8'd0,  1, 8'h00, 1);
        vecs[23] = v(1, 8'd5,  8'h55, 1, 8'd3,  0, 8'h00, 0);
        vecs[24] = v(0, 8'd0,  8'h00, 0, 8'd0,  1, 8'h13, 0);
        vecs[25] = v(0, 8'd0,  8'h00, 1, 8'd5,  0, 8'h13, 0);
        vecs[26] = v(0, 8'd0,  8'h00, 0, 8'd0,  1, 8'h55, 0);
        vecs[27] = v(0, 8'd0,  8'h00, 0, 8'd0,  0, 8'h55, 0);

        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        exp_mem[0] = 8'h10; exp_mem[1] = 8'h11; exp_mem[2] = 8'h12; exp_mem[3] = 8'h13;
        exp_mem[5] = 8'h55; exp_mem[7] = 8'h3C;

        // Reset state
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst.ready",  ready,  0);
        check("rst.rvalid", rvalid, 0);
        check("rst.err",    err,    0);
        check("rst.rdata",  rdata,  0);

        // Requests held through CLEAR must be ignored (write @9 lands after 9 was cleared).
        rst_n = 1'b1;
        enable = 1'b1; write = 1'b1; waddr = 8'd9; wdata = 8'h77;
        read = 1'b1; raddr = 8'd20;
        wait_ready("clear1");
        idle();
        check("clear1.ready_high", ready, 1);

        // Table-driven main sequence
        for (int i = 0; i < NVEC; i++) begin
            enable = vecs[i].we | vecs[i].re;
            write  = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
            read   = vecs[i].re; raddr = vecs[i].ra;
            tick();
            check($sformatf("vec%0d.rvalid", i), rvalid, vecs[i].exp_rv);
            check($sformatf("vec%0d.rdata",  i), rdata,  vecs[i].exp_rd);
            check($sformatf("vec%0d.err",    i), err,    vecs[i].exp_err);
        end
        idle();

        // Enable low masks requests
        write = 1'b1; waddr = 8'd4; wdata = 8'hEE; read = 1'b1; raddr = 8'd4;
        tick();
        tick();
        check("noen.rvalid", rvalid, 0);
        idle();

        // Full readback: out-of-range and masked writes left every word as modelled
        for (int i = 0; i < 16; i++) begin
            read_one($sformatf("rb%0d", i), 8'(i), exp_mem[i]);
        end

        // Reset while a read is in flight
        enable = 1'b1; read = 1'b1; raddr = 8'd3;
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        check("midrst.rvalid", rvalid, 0);
        check("midrst.ready",  ready,  0);
        check("midrst.rdata",  rdata,  0);
        rst_n = 1'b1;
        wait_ready("clear2");
        read_one("midrst.read3", 8'd3, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
